// File: rtl/reset_sequencer_if.sv
// Status and handshake bundle between the clock wizard / reset consumers and the reset sequencer.
// The master side drives lock, reset request and per-channel ready; the sequencer is the slave.
interface reset_sequencer_if #(
    parameter int NUM_CH    = 4,
    parameter int MAX_RETRY = 3
);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int STAGE_W = $clog2(NUM_CH + 1);

    logic               locked_in;
    logic               user_reset_in;
    logic [NUM_CH-1:0]  ch_ready_in;
    logic [NUM_CH-1:0]  ch_reset_out;
    logic               all_done_out;
    logic               fault_out;
    logic [RETRY_W-1:0] retry_cnt_out;
    logic [STAGE_W-1:0] stage_out;

    modport master (
        output locked_in, user_reset_in, ch_ready_in,
        input  ch_reset_out, all_done_out, fault_out, retry_cnt_out, stage_out
    );

    modport slave (
        input  locked_in, user_reset_in, ch_ready_in,
        output ch_reset_out, all_done_out, fault_out, retry_cnt_out, stage_out
    );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds all channel resets until lock plus a minimum time, then
// releases channels in index order, optionally waiting on a per-channel ready with bounded retry.
module reset_sequencer #(
    parameter int                CLK_PERIOD_NS    = 10,
    parameter int                NUM_CH           = 4,
    parameter int                MIN_ASSERT_NS    = 1000,
    parameter int                STEP_NS          = 1000,
    parameter logic [NUM_CH-1:0] READY_MASK       = '0,
    parameter int                READY_TIMEOUT_NS = 100000,
    parameter int                MAX_RETRY        = 3
) (
    input  logic              clk,
    input  logic              rst_n_in,
    reset_sequencer_if.slave  bus
);

    function automatic int ns_to_cyc(input int ns);
        int c;
        c = (ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
        return (c < 1) ? 1 : c;
    endfunction

    localparam int MIN_CYC = ns_to_cyc(MIN_ASSERT_NS);
    localparam int STEP_CYC = ns_to_cyc(STEP_NS);
    localparam int TO_CYC = ns_to_cyc(READY_TIMEOUT_NS);
    localparam int MAX_CYC = (MIN_CYC > STEP_CYC) ? ((MIN_CYC > TO_CYC) ? MIN_CYC : TO_CYC)
                                                  : ((STEP_CYC > TO_CYC) ? STEP_CYC : TO_CYC);
    localparam int CNT_W = $clog2(MAX_CYC) + 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int STAGE_W = $clog2(NUM_CH + 1);
    localparam int EXT_W = 2 ** STAGE_W;
    localparam logic [STAGE_W-1:0] LAST_CH = STAGE_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_HOLD, S_STAGE, S_DONE, S_FAULT} state_t;

    // Reset vector with channels 0..last released and everything above still asserted.
    function automatic logic [NUM_CH-1:0] reset_vec(input logic [STAGE_W-1:0] last);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = (i > int'(last));
        return v;
    endfunction

    (* ASYNC_REG = "TRUE" *) logic [NUM_CH+1:0] sync_ff1;
    (* ASYNC_REG = "TRUE" *) logic [NUM_CH+1:0] sync_ff2;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_ff1 <= '0;
            sync_ff2 <= '0;
        end else begin
            sync_ff1 <= {bus.user_reset_in, bus.locked_in, bus.ch_ready_in};
            sync_ff2 <= sync_ff1;
        end
    end

    logic              lock_s, urst_s, abort;
    logic [EXT_W-1:0]  rdy_ext, mask_ext;

    assign lock_s   = sync_ff2[NUM_CH];
    assign urst_s   = sync_ff2[NUM_CH+1];
    assign abort    = !lock_s || urst_s;
    // Padded to a power of two so a channel index of STAGE_W bits selects without truncation.
    assign rdy_ext  = {{(EXT_W - NUM_CH){1'b0}}, sync_ff2[NUM_CH-1:0]};
    assign mask_ext = {{(EXT_W - NUM_CH){1'b0}}, READY_MASK};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               waiting;
    logic [STAGE_W-1:0] cur_ch;
    logic [NUM_CH-1:0]  ch_reset_q;
    logic               all_done_q, fault_q;
    logic [RETRY_W-1:0] retry_q;
    logic [STAGE_W-1:0] stage_q;

    logic               advance, timeout, adv_final;
    logic [STAGE_W-1:0] adv_ch;

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        advance   = 1'b0;
        timeout   = 1'b0;
        adv_ch    = (state == S_HOLD) ? '0 : cur_ch + STAGE_W'(1);
        adv_final = (adv_ch == LAST_CH) && !mask_ext[adv_ch];
        case (state)
            S_HOLD:  advance = (cnt == CNT_W'(1));
            S_STAGE: begin
                if (!waiting) begin
                    advance = (cnt == CNT_W'(1)) && (!mask_ext[cur_ch] || rdy_ext[cur_ch]);
                end else begin
                    advance = rdy_ext[cur_ch];
                    timeout = !rdy_ext[cur_ch] && (cnt == CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values and the branch order below alone decides priority.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= S_HOLD;
            cnt        <= CNT_W'(MIN_CYC);
            waiting    <= 1'b0;
            cur_ch     <= '0;
            ch_reset_q <= '1;
            all_done_q <= 1'b0;
            fault_q    <= 1'b0;
            retry_q    <= '0;
            stage_q    <= '0;
        end else if (urst_s || (abort && state != S_FAULT)) begin
            state      <= S_HOLD;
            cnt        <= CNT_W'(MIN_CYC);
            waiting    <= 1'b0;
            cur_ch     <= '0;
            ch_reset_q <= '1;
            all_done_q <= 1'b0;
            stage_q    <= '0;
            if (urst_s) begin
                fault_q <= 1'b0;
                retry_q <= '0;
            end
        end else if (advance) begin
            if (state == S_STAGE && cur_ch == LAST_CH) begin
                state      <= S_DONE;
                all_done_q <= 1'b1;
            end else begin
                cur_ch     <= adv_ch;
                ch_reset_q <= reset_vec(adv_ch);
                stage_q    <= adv_ch + STAGE_W'(1);
                waiting    <= 1'b0;
                cnt        <= CNT_W'(STEP_CYC);
                // The last channel has nothing to dwell for unless it waits on a ready.
                if (adv_final) begin
                    state      <= S_DONE;
                    all_done_q <= 1'b1;
                end else begin
                    state <= S_STAGE;
                end
            end
        end else if (timeout) begin
            waiting    <= 1'b0;
            cur_ch     <= '0;
            ch_reset_q <= '1;
            stage_q    <= '0;
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
                retry_q <= retry_q + 1'b1;
                state   <= S_HOLD;
                cnt     <= CNT_W'(MIN_CYC);
            end else begin
                state   <= S_FAULT;
                fault_q <= 1'b1;
            end
        end else begin
            case (state)
                S_HOLD: cnt <= cnt - 1'b1;
                S_STAGE: begin
                    if (!waiting && cnt == CNT_W'(1)) begin
                        waiting <= 1'b1;
                        cnt     <= CNT_W'(TO_CYC);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ch_reset_out  = ch_reset_q;
    assign bus.all_done_out  = all_done_q;
    assign bus.fault_out     = fault_q;
    assign bus.retry_cnt_out = retry_q;
    assign bus.stage_out     = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: scenarios queue hand-computed output changes with the
// edge number (counted from reset release) on which each must appear; a monitor checks them.
module tb_reset_sequencer;

    localparam int NUM_CH    = 3;
    localparam int MAX_RETRY = 2;

    logic clk = 1'b0;
    logic rst_n_in;
    int   cyc;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_CH(NUM_CH), .MAX_RETRY(MAX_RETRY)) bus ();

    reset_sequencer #(
        .CLK_PERIOD_NS(10),
        .NUM_CH(NUM_CH),
        .MIN_ASSERT_NS(100),
        .STEP_NS(50),
        .READY_MASK(3'b010),
        .READY_TIMEOUT_NS(200),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .rst_n_in(rst_n_in),
        .bus(bus)
    );

    typedef struct packed {
        logic [2:0] ch;
        logic       done;
        logic       fault;
        logic [1:0] retry;
        logic [1:0] stage;
    } outs_t;

    typedef struct {
        int    edge_no;
        outs_t o;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string tname = "reset";
    outs_t prev;

    always @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic outs_t cur_outs();
        outs_t o;
        o.ch    = bus.ch_reset_out;
        o.done  = bus.all_done_out;
        o.fault = bus.fault_out;
        o.retry = bus.retry_cnt_out;
        o.stage = bus.stage_out;
        return o;
    endfunction

    task automatic expect_at(input int e, input logic [2:0] ch, input logic done,
                             input logic fault, input logic [1:0] retry, input logic [1:0] stage);
        exp_t x;
        x.edge_no = e;
        x.o = '{ch: ch, done: done, fault: fault, retry: retry, stage: stage};
        sb.push_back(x);
    endtask

    // Monitor: every output change while out of reset must match the next queued expectation.
    always @(negedge clk) begin
        outs_t now;
        exp_t  e;
        now = cur_outs();
        if (!rst_n_in) begin
            prev = now;
        end else if (now !== prev) begin
            if (sb.size() == 0) begin
                check({tname, " unexpected_change"}, 32'(now), 32'(prev));
            end else begin
                e = sb.pop_front();
                check({tname, " edge"}, cyc, e.edge_no);
                check({tname, " outputs"}, 32'(now), 32'(e.o));
            end
            prev = now;
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 5000);
        if (cyc != n) check({tname, " wait_timeout"}, cyc, n);
    endtask

    task automatic start(input string name, input logic [2:0] rdy);
        @(negedge clk);
        #1 rst_n_in = 1'b0;
        tname = name;
        sb.delete();
        bus.locked_in     = 1'b1;
        bus.user_reset_in = 1'b0;
        bus.ch_ready_in   = rdy;
        repeat (3) @(negedge clk);
        #1 rst_n_in = 1'b1;
    endtask

    task automatic drain(input int last);
        wait_cyc(last);
        check({tname, " pending"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in          = 1'b1;
        bus.locked_in     = 1'b0;
        bus.user_reset_in = 1'b0;
        bus.ch_ready_in   = 3'b000;
        #1 rst_n_in = 1'b0;
        #1;
        check("reset ch_reset", bus.ch_reset_out, 3'b111);
        check("reset all_done", bus.all_done_out, 1'b0);
        check("reset fault", bus.fault_out, 1'b0);
        check("reset retry", bus.retry_cnt_out, 2'd0);
        check("reset stage", bus.stage_out, 2'd0);

        // Nominal release, all readies present.
        start("nominal", 3'b111);
        expect_at(12, 3'b110, 0, 0, 0, 1);
        expect_at(17, 3'b100, 0, 0, 0, 2);
        expect_at(22, 3'b000, 1, 0, 0, 3);
        drain(30);

        // Channel 1 waits for its ready, which arrives before the timeout.
        start("ready_wait", 3'b101);
        expect_at(12, 3'b110, 0, 0, 0, 1);
        expect_at(17, 3'b100, 0, 0, 0, 2);
        expect_at(32, 3'b000, 1, 0, 0, 3);
        wait_cyc(29);
        bus.ch_ready_in = 3'b111;
        drain(40);

        // Ready never comes: two retries, then fault; user reset clears it and restarts.
        start("retry_fault", 3'b101);
        expect_at(12,  3'b110, 0, 0, 0, 1);
        expect_at(17,  3'b100, 0, 0, 0, 2);
        expect_at(42,  3'b111, 0, 0, 1, 0);
        expect_at(52,  3'b110, 0, 0, 1, 1);
        expect_at(57,  3'b100, 0, 0, 1, 2);
        expect_at(82,  3'b111, 0, 0, 2, 0);
        expect_at(92,  3'b110, 0, 0, 2, 1);
        expect_at(97,  3'b100, 0, 0, 2, 2);
        expect_at(122, 3'b111, 0, 1, 2, 0);
        expect_at(133, 3'b111, 0, 0, 0, 0);
        expect_at(143, 3'b110, 0, 0, 0, 1);
        expect_at(148, 3'b100, 0, 0, 0, 2);
        expect_at(153, 3'b000, 1, 0, 0, 3);
        wait_cyc(130);
        bus.user_reset_in = 1'b1;
        wait_cyc(131);
        bus.user_reset_in = 1'b0;
        wait_cyc(140);
        bus.ch_ready_in = 3'b111;
        drain(160);

        // Lock drops during STAGE(1); full HOLD re-runs after it returns.
        start("lock_loss", 3'b111);
        expect_at(12, 3'b110, 0, 0, 0, 1);
        expect_at(17, 3'b100, 0, 0, 0, 2);
        expect_at(21, 3'b111, 0, 0, 0, 0);
        expect_at(37, 3'b110, 0, 0, 0, 1);
        expect_at(42, 3'b100, 0, 0, 0, 2);
        expect_at(47, 3'b000, 1, 0, 0, 3);
        wait_cyc(18);
        bus.locked_in = 1'b0;
        wait_cyc(25);
        bus.locked_in = 1'b1;
        drain(55);

        // Synchronised user reset lands on the final-release edge: abort wins.
        start("urst_vs_done", 3'b111);
        expect_at(12, 3'b110, 0, 0, 0, 1);
        expect_at(17, 3'b100, 0, 0, 0, 2);
        expect_at(22, 3'b111, 0, 0, 0, 0);
        expect_at(32, 3'b110, 0, 0, 0, 1);
        expect_at(37, 3'b100, 0, 0, 0, 2);
        expect_at(42, 3'b000, 1, 0, 0, 3);
        wait_cyc(19);
        bus.user_reset_in = 1'b1;
        wait_cyc(20);
        bus.user_reset_in = 1'b0;
        drain(50);

        // Asynchronous reset in STAGE(1) takes effect between clock edges.
        start("async_reset", 3'b111);
        expect_at(12, 3'b110, 0, 0, 0, 1);
        expect_at(17, 3'b100, 0, 0, 0, 2);
        wait_cyc(19);
        check({tname, " pending"}, sb.size(), 0);
        #2 rst_n_in = 1'b0;
        #1;
        check("async_reset ch_reset", bus.ch_reset_out, 3'b111);
        check("async_reset all_done", bus.all_done_out, 1'b0);
        check("async_reset fault", bus.fault_out, 1'b0);
        check("async_reset retry", bus.retry_cnt_out, 2'd0);
        check("async_reset stage", bus.stage_out, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised multi-channel reset sequencer; successor to the single-output delayed system reset.
- Holds NUM_CH active-high reset outputs, then releases them one by one in index order after PLL/MMCM lock and a minimum assert time.
- Each channel can optionally wait for a ready handshake (e.g. IDELAYCTRL RDY, transceiver reset-done), with timeout and bounded retry.
- Sits directly after the clock wizard. Drives per-domain resets, which are re-synchronised by sync_reset at each consumer.

Parameters:
- CLK_PERIOD_NS, 10, period of clk in ns; used for all ns-to-cycle conversions.
- NUM_CH, 4, number of reset channels (1..16).
- MIN_ASSERT_NS, 1000, minimum time all channels stay asserted in HOLD.
- STEP_NS, 1000, dwell after releasing channel k before channel k+1 may be released.
- READY_MASK, {NUM_CH{1'b0}}, bit k=1: channel k must see ch_ready_in[k] before sequencing continues.
- READY_TIMEOUT_NS, 100000, maximum wait for a masked ready, counted after the step dwell.
- MAX_RETRY, 3, timeouts tolerated before FAULT (0 = first timeout faults).

Ports:
- clk, in, 1, sequencer clock (free-running, e.g. 100 MHz).
- rst_n_in, in, 1, asynchronous active-low reset.
- locked_in, in, 1, clock-wizard locked; asynchronous.
- user_reset_in, in, 1, active-high reset request; asynchronous.
- ch_ready_in, in, NUM_CH, per-channel ready, any clock domain.
- ch_reset_out, out, NUM_CH, active-high per-channel resets, registered.
- all_done_out, out, 1, 1 when every channel is released and all masked readies have been seen.
- fault_out, out, 1, sticky fault after retries are exhausted.
- retry_cnt_out, out, clog2(MAX_RETRY+1) (min 1), number of timeouts since the last clear.
- stage_out, out, clog2(NUM_CH+1) (min 1), count of channels currently released.

Behaviour:
- Cycle constants: MIN_CYC, STEP_CYC and TO_CYC = ceil(ns / CLK_PERIOD_NS), each clamped to at least 1. Counter widths come from $clog2 of these values plus 1.
- Synchronisers: locked_in, user_reset_in and ch_ready_in each pass through a 2-flop ASYNC_REG synchroniser. This adds 2 cycles of input latency. The synchronised signals are lock_s, urst_s and rdy_s.
- rst_n_in low (async): ch_reset_out = all 1s; all_done_out = 0; fault_out = 0; retry_cnt_out = 0; stage_out = 0; state = HOLD; counters loaded; synchronisers cleared.
- Abort condition = !lock_s || urst_s. It has priority over every other transition.
  - On abort, in any state except FAULT: next edge sets ch_reset_out to all 1s, stage_out = 0, all_done_out = 0, state = HOLD, HOLD counter reloaded to MIN_CYC.
- urst_s additionally clears fault_out and retry_cnt_out, and exits FAULT to HOLD. Lock loss alone does not exit FAULT.
- HOLD: the counter decrements only while abort is false. On the edge where it reaches 0, go to STAGE(0): ch_reset_out[0] deasserts and stage_out = 1 on that same edge.
- STAGE(k): channels 0..k are released; channels above k are asserted.
  - Step counter runs STEP_CYC cycles.
  - If READY_MASK[k] = 0, advance when the step counter expires.
  - If READY_MASK[k] = 1, advance on the first edge where the step counter has expired and rdy_s[k] = 1. The timeout counter starts when the step counter expires.
  - Advance from k < NUM_CH-1: release channel k+1 and go to STAGE(k+1).
  - Advance from k = NUM_CH-1: go to DONE and set all_done_out = 1 on that edge.
- Timeout: TO_CYC cycles elapse without rdy_s[k].
  - If retry_cnt_out < MAX_RETRY: increment retry_cnt_out; reassert all channels; go to HOLD.
  - Otherwise: go to FAULT.
  - If a timeout and rdy_s[k] rising occur on the same edge, ready wins and there is no timeout.
- DONE: outputs hold. Later ready deassertions are ignored. retry_cnt_out is retained for diagnostics.
- FAULT: ch_reset_out = all 1s; fault_out = 1; all_done_out = 0; stage_out = 0. Stays in FAULT until urst_s or rst_n_in.
- A release is never skipped and never reordered. Channel k is never released while channel j < k is asserted.
- NUM_CH = 1: the block degenerates to delay-after-lock plus an optional ready wait.

Test Plan:
Common configuration: CLK_PERIOD_NS=10, NUM_CH=3, MIN_ASSERT_NS=100 (10 cycles), STEP_NS=50 (5), READY_MASK=3'b010, READY_TIMEOUT_NS=200 (20), MAX_RETRY=2.
1. Nominal: release rst_n_in with locked_in=1 and ch_ready_in=3'b111 -> ch_reset_out 3'b111 -> 3'b110 at edge 12 (2 sync + 10 HOLD) -> 3'b100 at edge 17 -> 3'b000 at edge 22; all_done_out=1 at edge 22; retry_cnt_out=0.
2. Ready wait: ch_ready_in[1]=0 until edge 30, then 1 -> ch2 is released on edge 32 (2-cycle sync); all_done_out=1 on edge 32; retry_cnt_out=0.
3. Timeout/retry/fault: ch_ready_in[1] held at 0 -> three timeouts; retry_cnt_out goes 1, then 2; the third timeout sets fault_out=1 with ch_reset_out=3'b111. Then pulse user_reset_in -> fault_out=0, retry_cnt_out=0, and the sequence restarts.
4. Lock loss mid-sequence: drop locked_in in STAGE(1) -> ch_reset_out=3'b111 exactly 3 edges later; stage_out=0. Restore lock -> the full HOLD of 10 cycles is re-run before ch0 releases.
5. Simultaneous events: make user_reset_in's synchronised edge coincide with the STAGE(2)->DONE advance edge -> abort wins; all_done_out stays 0; ch_reset_out=3'b111.
6. Async reset mid-STAGE(1): assert rst_n_in low -> all outputs take their reset values immediately, without waiting for a clk edge.
